// File: rtl/result_dumper.sv
// result_dumper: after end_process rises, reads a window of data memory
// through mem_addr/mem_data and sends each byte on tx as 8N1 UART frames.
// Ports: clk, rst_n (sync, active-low), end_process, mem_data[7:0] in;
//        mem_addr[15:0], tx, busy, done out (all registered).
module result_dumper #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter int unsigned NUM_BYTES    = 16,
  parameter int unsigned READ_WAIT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        end_process,
  input  logic [7:0]  mem_data,
  output logic [15:0] mem_addr,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned RW_W =
    (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [RW_W-1:0] RW_LAST =
    RW_W'(READ_WAIT - 1);
  localparam logic [15:0] BIT_LAST =
    16'(CLKS_PER_BIT - 1);
  localparam logic [16:0] BYTE_LAST =
    17'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic            prev_ep;
  logic            trig;
  logic [RW_W-1:0] wait_cnt;
  logic [15:0]     clk_cnt;
  logic [2:0]      bit_idx;
  logic [16:0]     byte_cnt;
  logic [7:0]      shreg;
  logic [7:0]      shreg_n;
  logic            bit_end;
  logic            fetch_end;
  logic            last_byte;
  logic            tx_n;
  logic            busy_n;
  logic            done_n;

  assign bit_end   = (clk_cnt == BIT_LAST);
  assign fetch_end = (wait_cnt == RW_LAST);
  assign last_byte = (byte_cnt == BYTE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    unique case (state)
      IDLE: begin
        if (trig) state_n = FETCH;
      end
      FETCH: begin
        if (fetch_end) begin
          state_n = START;
          shreg_n = mem_data;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) state_n = STOP;
          else shreg_n = {1'b0, shreg[7:1]};
        end
      end
      STOP: begin
        if (bit_end)
          state_n = last_byte ? DONE : FETCH;
      end
      DONE: begin
        if (!end_process) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so derive them from the next state.
    tx_n   = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    unique case (state_n)
      FETCH:   busy_n = 1'b1;
      START: begin
        busy_n = 1'b1;
        tx_n   = 1'b0;
      end
      DATA: begin
        busy_n = 1'b1;
        tx_n   = shreg_n[0];
      end
      STOP:    busy_n = 1'b1;
      DONE:    done_n = 1'b1;
      default: tx_n   = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_ep  <= 1'b0;
      trig     <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      wait_cnt <= '0;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      mem_addr <= START_ADDR;
    end else begin
      prev_ep <= end_process;
      // Edge captured one cycle ahead of the FETCH entry.
      trig    <= (state == IDLE) &&
                 end_process && !prev_ep;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
      shreg   <= shreg_n;

      if (state == FETCH && !fetch_end)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if ((state == START || state == DATA ||
           state == STOP) && !bit_end)
        clk_cnt <= clk_cnt + 16'd1;
      else
        clk_cnt <= '0;

      if (state == DATA && bit_end)
        bit_idx <= bit_idx + 3'd1;

      if (state == IDLE && trig) begin
        mem_addr <= START_ADDR;
        byte_cnt <= '0;
      end else if (state == STOP && bit_end &&
                   !last_byte) begin
        mem_addr <= mem_addr + 16'd1;
        byte_cnt <= byte_cnt + 17'd1;
      end
    end
  end

endmodule

// File: tb/tb_result_dumper.sv
// tb_result_dumper: two dumper instances (1 byte at 0000, 4 bytes at
// FFFE) checked against a cycle-arithmetic model and literal values.
module tb_result_dumper;

  localparam int C  = 4;
  localparam int RW = 2;
  localparam int P  = RW + 10 * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  ep;
  logic [7:0]  md0 = 8'h00;
  logic [7:0]  md1 = 8'h00;
  logic [15:0] a0;
  logic [15:0] a1;
  logic [1:0]  tx_o;
  logic [1:0]  busy_o;
  logic [1:0]  done_o;

  result_dumper #(
    .CLKS_PER_BIT(C),
    .START_ADDR(16'h0000),
    .NUM_BYTES(1),
    .READ_WAIT(RW)
  ) u_one (
    .clk(clk),
    .rst_n(rst_n),
    .end_process(ep[0]),
    .mem_data(md0),
    .mem_addr(a0),
    .tx(tx_o[0]),
    .busy(busy_o[0]),
    .done(done_o[0])
  );

  result_dumper #(
    .CLKS_PER_BIT(C),
    .START_ADDR(16'hFFFE),
    .NUM_BYTES(4),
    .READ_WAIT(RW)
  ) u_multi (
    .clk(clk),
    .rst_n(rst_n),
    .end_process(ep[1]),
    .mem_data(md1),
    .mem_addr(a1),
    .tx(tx_o[1]),
    .busy(busy_o[1]),
    .done(done_o[1])
  );

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    md0 <= 8'hA5;
    md1 <= a1[7:0];
  end

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] s_of(int i);
    return (i == 0) ? 16'h0000 : 16'hFFFE;
  endfunction

  function automatic int n_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] mem_f(int i, logic [15:0] a);
    return (i == 0) ? 8'hA5 : a[7:0];
  endfunction

  // Model: outputs follow from cycles elapsed since the trigger edge.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t       mode [2];
  bit          mprev [2];
  int          t0 [2];
  logic        ex_tx [2];
  logic        ex_busy [2];
  logic        ex_done [2];
  logic [15:0] ex_addr [2];
  int          mk, mj, mb, moff, mbp;
  logic [7:0]  md;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mode[i]    = M_IDLE;
        mprev[i]   = 1'b0;
        ex_tx[i]   = 1'b1;
        ex_busy[i] = 1'b0;
        ex_done[i] = 1'b0;
        ex_addr[i] = s_of(i);
      end else begin
        case (mode[i])
          M_IDLE: begin
            if (ep[i] && !mprev[i]) begin
              mode[i] = M_RUN;
              t0[i]   = cyc;
            end
          end
          M_RUN: begin
            mk = cyc - t0[i];
            if (mk == 1 + n_of(i) * P) begin
              mode[i]    = M_DONE;
              ex_busy[i] = 1'b0;
              ex_done[i] = 1'b1;
              ex_tx[i]   = 1'b1;
            end else begin
              mj   = mk - 1;
              mb   = mj / P;
              moff = mj % P;
              ex_addr[i] = s_of(i) + 16'(mb);
              ex_busy[i] = 1'b1;
              if (moff < RW) begin
                ex_tx[i] = 1'b1;
              end else begin
                mbp = (moff - RW) / C;
                md  = mem_f(i, ex_addr[i]);
                if (mbp == 0)      ex_tx[i] = 1'b0;
                else if (mbp == 9) ex_tx[i] = 1'b1;
                else               ex_tx[i] = md[mbp-1];
              end
            end
          end
          default: begin
            if (!ep[i]) begin
              mode[i]    = M_IDLE;
              ex_done[i] = 1'b0;
            end
          end
        endcase
        mprev[i] = ep[i];
      end
    end
  end

  logic [15:0] av;
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        av = (i == 0) ? a0 : a1;
        checks++;
        if (tx_o[i] !== ex_tx[i] ||
            busy_o[i] !== ex_busy[i] ||
            done_o[i] !== ex_done[i] ||
            av !== ex_addr[i]) begin
          errors++;
          $display("FAIL model%0d cyc=%0d tx=%b/%b busy=%b/%b done=%b/%b addr=%h/%h (got/want)",
                   i, cyc, tx_o[i], ex_tx[i], busy_o[i], ex_busy[i],
                   done_o[i], ex_done[i], av, ex_addr[i]);
        end
      end
    end
  end

  // UART decoders and address recorder.
  bit          din [2];
  int          dcnt [2];
  logic [7:0]  dsh [2];
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  logic [15:0] aq [$];
  logic        pbusy1 = 1'b0;
  logic [15:0] pa1 = 16'h0000;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        din[i] = 1'b0;
      end else if (!din[i]) begin
        if (tx_o[i] === 1'b0) begin
          din[i]  = 1'b1;
          dcnt[i] = 0;
        end
      end else begin
        dcnt[i]++;
        if (dcnt[i] % C == C / 2 && dcnt[i] / C >= 1 &&
            dcnt[i] / C <= 8)
          dsh[i][dcnt[i]/C-1] = tx_o[i];
        if (dcnt[i] == 9 * C + C / 2) begin
          din[i] = 1'b0;
          if (i == 0) q0.push_back(dsh[i]);
          else        q1.push_back(dsh[i]);
        end
      end
    end
    if (busy_o[1] === 1'b1 && (!pbusy1 || a1 != pa1))
      aq.push_back(a1);
    pbusy1 = busy_o[1];
    pa1    = a1;
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic [9:0]  pat = 10'b1101001010;
  logic [7:0]  mb_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic [15:0] ma_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  int T;
  int dc;

  initial begin
    rst_n = 1'b0;
    ep    = 2'b00;
    step();
    for (int r = 0; r < 3; r++) begin
      chk("rst_tx", tx_o, 2'b11);
      chk("rst_busy", busy_o, 2'b00);
      chk("rst_done", done_o, 2'b00);
      chk("rst_addr0", a0, 16'h0000);
      chk("rst_addr1", a1, 16'hFFFE);
      ep = ~ep;
      step();
    end
    ep    = 2'b00;
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_tx", tx_o, 2'b11);

    // Both dumps triggered on the same edge.
    ep = 2'b11;
    T  = cyc + 1;
    for (int c = 0; c <= 169; c++) begin
      step();
      if (c == 0) chk("busy_t0", busy_o, 2'b00);
      if (c == 1) begin
        chk("busy_t1", busy_o, 2'b11);
        chk("addr_t1", a1, 16'hFFFE);
      end
      if (c == 2) chk("pre_start", tx_o[0], 1'b1);
      if (c >= 3 && c < 43 &&
          ((c - 3) % 4 == 0 || (c - 3) % 4 == 3))
        chk("a5_bit", tx_o[0], pat[(c-3)/4]);
      if (c == 42) chk("done0_42", done_o[0], 1'b0);
      if (c == 43) begin
        chk("done0_43", done_o[0], 1'b1);
        chk("busy0_43", busy_o[0], 1'b0);
      end
      if (c == 168) chk("done1_168", done_o[1], 1'b0);
      if (c == 169) chk("done1_169", done_o[1], 1'b1);
    end
    chk("q0_size", q0.size(), 1);
    chk("q0_byte", (q0.size() > 0) ? 32'(q0[0]) : 32'hDEAD, 8'hA5);
    chk("q1_size", q1.size(), 4);
    chk("aq_size", aq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("q1_byte", (k < q1.size()) ? 32'(q1[k]) : 32'hDEAD,
          32'(mb_exp[k]));
      chk("addr_seq", (k < aq.size()) ? 32'(aq[k]) : 32'hDEAD,
          32'(ma_exp[k]));
    end

    // Held high after done: no new frame.
    repeat (100) step();
    chk("hold_done", done_o[1], 1'b1);
    chk("hold_busy", busy_o[1], 1'b0);
    chk("hold_q1", q1.size(), 4);
    ep = 2'b00;
    step();
    step();
    chk("rearm_clr", done_o, 2'b00);

    // Second dump with ignored edges while busy.
    ep[1] = 1'b1;
    dc    = -1;
    for (int c = 0; c <= 400; c++) begin
      step();
      if (c == 50) ep[1] = 1'b0;
      if (c == 60) ep[1] = 1'b1;
      if (c == 70) ep[1] = 1'b0;
      if (c == 80) ep[1] = 1'b1;
      if (done_o[1] === 1'b1) begin
        dc = c;
        break;
      end
    end
    chk("rerun_len", dc, 169);
    chk("rerun_q1", q1.size(), 8);
    for (int k = 0; k < 4; k++)
      chk("rerun_byte",
          (k + 4 < q1.size()) ? 32'(q1[k+4]) : 32'hDEAD,
          32'(mb_exp[k]));
    repeat (30) step();
    chk("no_restart", busy_o[1], 1'b0);
    chk("no_restart_q", q1.size(), 8);

    // Reset during DATA bit 3 of the first byte.
    ep = 2'b00;
    step();
    step();
    ep[1] = 1'b1;
    T     = cyc + 1;
    for (int c = 0; c <= 19; c++) step();
    chk("bit3_busy", busy_o[1], 1'b1);
    chk("bit3_tx", tx_o[1], 1'b1);
    rst_n = 1'b0;
    step();
    chk("mid_tx", tx_o[1], 1'b1);
    chk("mid_busy", busy_o[1], 1'b0);
    chk("mid_addr", a1, 16'hFFFE);
    rst_n = 1'b1;
    step();
    chk("rel_busy0", busy_o[1], 1'b0);
    step();
    chk("rel_busy1", busy_o[1], 1'b1);
    chk("rel_addr", a1, 16'hFFFE);
    dc = -1;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (done_o[1] === 1'b1) begin
        dc = c;
        break;
      end
    end
    chk("rel_len", dc, 168);
    chk("rel_q1", q1.size(), 12);
    for (int k = 0; k < 4; k++)
      chk("rel_byte",
          (k + 8 < q1.size()) ? 32'(q1[k+8]) : 32'hDEAD,
          32'(mb_exp[k]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
